uart_block_packer: RTL

- Sits directly downstream of uart_rx and consumes its data_out/data_ready byte stream.
- Packs consecutive received bytes big-endian into one BLOCK_BYTES-wide message block and hands it to the hash core over a valid/ready handshake.
- Discards a stale partial block after an inter-byte timeout.
- Flags bytes lost while a full block waits for the consumer.

---
 rtl/uart_block_packer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_block_packer.sv
// Packs rising-edge-qualified uart_rx bytes big-endian into BLOCK_BYTES-wide blocks
// and offers them on a valid/ready handshake, with partial-block timeout and sticky overrun.
module uart_block_packer #(
    parameter int BLOCK_BYTES    = 64,
    parameter int TIMEOUT_CYCLES = 1041600
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       data_in,
    input  logic                             data_ready,
    output logic [BLOCK_BYTES*8-1:0]         block_out,
    output logic                             block_valid,
    input  logic                             block_ready,
    output logic [$clog2(BLOCK_BYTES+1)-1:0] byte_count,
    output logic                             overrun,
    output logic                             timeout_pulse
);

    localparam int BW        = BLOCK_BYTES * 8;
    localparam int CW        = $clog2(BLOCK_BYTES + 1);
    localparam int TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] TO_LAST    = TW'(TO_LAST_I);
    localparam logic [CW-1:0] LAST_COUNT = CW'(BLOCK_BYTES - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic            data_ready_q_r;
    logic [BW-1:0]   block_out_r, block_out_s;
    logic            block_valid_r, block_valid_s;
    logic [CW-1:0]   byte_count_r, byte_count_s;
    logic            overrun_r, overrun_s;
    logic            timeout_pulse_r, timeout_pulse_s;
    logic [TW-1:0]   timeout_cnt_r, timeout_cnt_s;
    logic            strobe_s;

    // A held-high data_ready yields one strobe; data_in is taken in the same cycle.
    assign strobe_s = data_ready & ~data_ready_q_r;

    // Next-state, datapath and handshake decisions.
    always_comb begin
        state_s         = state_r;
        block_out_s     = block_out_r;
        block_valid_s   = block_valid_r;
        byte_count_s    = byte_count_r;
        overrun_s       = overrun_r;
        timeout_pulse_s = 1'b0;
        timeout_cnt_s   = timeout_cnt_r;
        case (state_r)
            COLLECT: begin
                if (strobe_s) begin
                    block_out_s   = {block_out_r[BW-9:0], data_in};
                    byte_count_s  = byte_count_r + CW'(1);
                    timeout_cnt_s = '0;
                    if (byte_count_r == LAST_COUNT) begin
                        block_valid_s = 1'b1;
                        state_s       = HOLD;
                    end else begin
                        state_s       = COLLECT;
                    end
                end else if ((TIMEOUT_CYCLES > 0) && (byte_count_r != '0)) begin
                    // A strobe arriving on the firing cycle wins via the branch above.
                    if (timeout_cnt_r == TO_LAST) begin
                        byte_count_s    = '0;
                        block_out_s     = '0;
                        timeout_cnt_s   = '0;
                        timeout_pulse_s = 1'b1;
                    end else begin
                        timeout_cnt_s   = timeout_cnt_r + TW'(1);
                    end
                end else begin
                    timeout_cnt_s = '0;
                end
            end
            HOLD: begin
                timeout_cnt_s = '0;
                if (block_ready) begin
                    block_valid_s = 1'b0;
                    state_s       = COLLECT;
                    if (strobe_s) begin
                        block_out_s  = {{(BW-8){1'b0}}, data_in};
                        byte_count_s = CW'(1);
                    end else begin
                        block_out_s  = '0;
                        byte_count_s = '0;
                    end
                end else if (strobe_s) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
            end
            default: begin
                state_s       = COLLECT;
                block_out_s   = '0;
                block_valid_s = 1'b0;
                byte_count_s  = '0;
                timeout_cnt_s = '0;
            end
        endcase
    end

    // State and output registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= COLLECT;
            data_ready_q_r  <= 1'b0;
            block_out_r     <= '0;
            block_valid_r   <= 1'b0;
            byte_count_r    <= '0;
            overrun_r       <= 1'b0;
            timeout_pulse_r <= 1'b0;
            timeout_cnt_r   <= '0;
        end else begin
            state_r         <= state_s;
            data_ready_q_r  <= data_ready;
            block_out_r     <= block_out_s;
            block_valid_r   <= block_valid_s;
            byte_count_r    <= byte_count_s;
            overrun_r       <= overrun_s;
            timeout_pulse_r <= timeout_pulse_s;
            timeout_cnt_r   <= timeout_cnt_s;
        end
    end

    assign block_out     = block_out_r;
    assign block_valid   = block_valid_r;
    assign byte_count    = byte_count_r;
    assign overrun       = overrun_r;
    assign timeout_pulse = timeout_pulse_r;

endmodule
